// File: rtl/mtx_issue_sched.sv
// rtl/mtx_issue_sched.sv - issue sequencer for the DIM x DIM matrix-multiply datapath
// Walks row-major index pairs into the dot-product unit and shadows them to the result buffer.
module mtx_issue_sched #(
    parameter int DIM_LOG2  = 3,
    parameter int PIPE_LAT  = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic                  STALL,
    output logic [DIM_LOG2-1:0]   A_SELECT,
    output logic [DIM_LOG2-1:0]   B_SELECT,
    output logic                  ISSUE_VALID,
    output logic                  WR_EN,
    output logic [2*DIM_LOG2-1:0] WR_ADDR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [1:0]            STATUS,
    output logic [CNT_WIDTH-1:0]  CYCLES
);

    localparam int               IDX_W    = 2 * DIM_LOG2;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [PIPE_LAT-1:0] sh_valid;
    logic [IDX_W-1:0]    sh_addr [PIPE_LAT];

    logic issue;
    logic abort_run;
    logic start_ok;
    logic last_retire;

    // Issue is a same-cycle function of STALL so a stalled cycle never presents an index.
    assign issue       = (state == S_ISSUE) && !STALL;
    assign abort_run   = ABORT && (state != S_IDLE);
    assign start_ok    = START && !ABORT && (state == S_IDLE);
    assign last_retire = WR_EN && (WR_ADDR == LAST_IDX);

    assign ISSUE_VALID = issue;
    assign A_SELECT    = idx[IDX_W-1:DIM_LOG2];
    assign B_SELECT    = idx[DIM_LOG2-1:0];
    assign WR_EN       = sh_valid[PIPE_LAT-1];
    assign WR_ADDR     = sh_addr[PIPE_LAT-1];
    assign BUSY        = (state == S_ISSUE) || (state == S_DRAIN);
    assign DONE        = (state == S_DONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            idx    <= '0;
            STATUS <= 2'b00;
            CYCLES <= '0;
        end else begin
            // The abort cycle itself still counts: the run was busy during it.
            if (start_ok) begin
                CYCLES <= '0;
            end else if ((state != S_IDLE) && (CYCLES != {CNT_WIDTH{1'b1}})) begin
                CYCLES <= CYCLES + 1'b1;
            end

            if (abort_run) begin
                state  <= S_IDLE;
                STATUS <= 2'b11;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            state  <= S_ISSUE;
                            idx    <= '0;
                            STATUS <= 2'b01;
                        end
                    end
                    S_ISSUE: begin
                        if (issue) begin
                            idx <= idx + 1'b1;
                            if (idx == LAST_IDX) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (last_retire) begin
                            state  <= S_DONE;
                            STATUS <= 2'b10;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Shadow of the free-running dot-product pipeline; only reset or abort empties it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sh_valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                sh_addr[i] <= '0;
            end
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                sh_valid[i] <= sh_valid[i-1];
                sh_addr[i]  <= sh_addr[i-1];
            end
            sh_valid[0] <= issue;
            sh_addr[0]  <= idx;
            if (abort_run) begin
                sh_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mtx_issue_sched.sv
// tb/tb_mtx_issue_sched.sv - directed-vector bench for mtx_issue_sched
module tb_mtx_issue_sched;

    localparam int N = 120;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic        STALL = 1'b0;
    logic [2:0]  A_SELECT;
    logic [2:0]  B_SELECT;
    logic        ISSUE_VALID;
    logic        WR_EN;
    logic [5:0]  WR_ADDR;
    logic        BUSY;
    logic        DONE;
    logic [1:0]  STATUS;
    logic [31:0] CYCLES;

    mtx_issue_sched #(
        .DIM_LOG2 (3),
        .PIPE_LAT (4),
        .CNT_WIDTH(32)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .ABORT      (ABORT),
        .STALL      (STALL),
        .A_SELECT   (A_SELECT),
        .B_SELECT   (B_SELECT),
        .ISSUE_VALID(ISSUE_VALID),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .STATUS     (STATUS),
        .CYCLES     (CYCLES)
    );

    always #5 CLK = ~CLK;

    logic        st_v [N];
    logic        ab_v [N];
    logic        sl_v [N];
    logic        rs_v [N];
    logic        r_iv [N];
    logic        r_we [N];
    logic        r_busy [N];
    logic        r_done [N];
    logic [5:0]  r_idx [N];
    logic [5:0]  r_wa [N];
    logic [1:0]  r_st [N];
    logic [31:0] r_cyc [N];
    logic        e_iv [N];
    logic        e_we [N];
    logic        e_busy [N];
    logic        e_done [N];
    int          e_idx [N];
    int          e_wa [N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            st_v[i] = 0; ab_v[i] = 0; sl_v[i] = 0; rs_v[i] = 0;
            e_iv[i] = 0; e_we[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            e_idx[i] = 0; e_wa[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; STALL = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge CLK); #1;
            START = st_v[c]; ABORT = ab_v[c]; STALL = sl_v[c]; RST = rs_v[c];
            @(negedge CLK);
            r_iv[c]   = ISSUE_VALID;
            r_idx[c]  = {A_SELECT, B_SELECT};
            r_we[c]   = WR_EN;
            r_wa[c]   = WR_ADDR;
            r_busy[c] = BUSY;
            r_done[c] = DONE;
            r_st[c]   = STATUS;
            r_cyc[c]  = CYCLES;
        end
        START = 1'b0; ABORT = 1'b0; STALL = 1'b0; RST = 1'b0;
    endtask

    task automatic exp_issue(input int lo, input int hi, input int first);
        for (int c = lo; c <= hi; c++) begin
            e_iv[c] = 1; e_idx[c] = first + (c - lo);
        end
    endtask

    task automatic exp_write(input int lo, input int hi, input int first);
        for (int c = lo; c <= hi; c++) begin
            e_we[c] = 1; e_wa[c] = first + (c - lo);
        end
    endtask

    task automatic exp_busy(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) e_busy[c] = 1;
    endtask

    task automatic compare_all(input string nm, input int n);
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s iv@%0d", nm, c), r_iv[c], e_iv[c]);
            if (e_iv[c]) check($sformatf("%s idx@%0d", nm, c), r_idx[c], e_idx[c]);
            check($sformatf("%s we@%0d", nm, c), r_we[c], e_we[c]);
            if (e_we[c]) check($sformatf("%s wa@%0d", nm, c), r_wa[c], e_wa[c]);
            check($sformatf("%s busy@%0d", nm, c), r_busy[c], e_busy[c]);
            check($sformatf("%s done@%0d", nm, c), r_done[c], e_done[c]);
        end
    endtask

    initial begin
        // Reset values while RST is held from time zero.
        @(negedge CLK);
        check("rst a_sel", A_SELECT, 0);
        check("rst b_sel", B_SELECT, 0);
        check("rst iv", ISSUE_VALID, 0);
        check("rst we", WR_EN, 0);
        check("rst wa", WR_ADDR, 0);
        check("rst busy", BUSY, 0);
        check("rst done", DONE, 0);
        check("rst status", STATUS, 0);
        check("rst cycles", CYCLES, 0);

        // Basic run
        clear_all(); do_reset();
        st_v[0] = 1;
        run(80);
        exp_issue(1, 64, 0); exp_write(5, 68, 0); exp_busy(1, 68); e_done[69] = 1;
        compare_all("basic", 80);
        check("basic status busy", r_st[1], 2'b01);
        check("basic status end", r_st[79], 2'b10);
        check("basic cycles", r_cyc[79], 69);

        // Stall during issue
        clear_all(); do_reset();
        st_v[0] = 1;
        for (int c = 10; c <= 14; c++) sl_v[c] = 1;
        run(85);
        exp_issue(1, 9, 0); exp_issue(15, 69, 9);
        exp_write(5, 13, 0); exp_write(19, 73, 9);
        exp_busy(1, 73); e_done[74] = 1;
        compare_all("stall", 85);
        check("stall status", r_st[84], 2'b10);
        check("stall cycles", r_cyc[84], 74);

        // Stall during drain has no effect
        clear_all(); do_reset();
        st_v[0] = 1;
        for (int c = 66; c <= 68; c++) sl_v[c] = 1;
        run(80);
        exp_issue(1, 64, 0); exp_write(5, 68, 0); exp_busy(1, 68); e_done[69] = 1;
        compare_all("dstall", 80);
        check("dstall cycles", r_cyc[79], 69);

        // Abort then restart
        clear_all(); do_reset();
        st_v[0] = 1; ab_v[20] = 1; st_v[30] = 1;
        run(105);
        exp_issue(1, 20, 0); exp_issue(31, 94, 0);
        exp_write(5, 20, 0); exp_write(35, 98, 0);
        exp_busy(1, 20); exp_busy(31, 98); e_done[99] = 1;
        compare_all("abort", 105);
        check("abort status", r_st[21], 2'b11);
        check("abort status hold", r_st[30], 2'b11);
        check("abort cycles", r_cyc[21], 20);
        check("abort cycles frozen", r_cyc[30], 20);
        check("restart status", r_st[31], 2'b01);
        check("restart cycles", r_cyc[104], 69);
        check("restart status end", r_st[104], 2'b10);

        // Start while busy ignored; start+abort together aborts
        clear_all(); do_reset();
        st_v[0] = 1; st_v[30] = 1; st_v[40] = 1; ab_v[40] = 1;
        run(60);
        exp_issue(1, 40, 0); exp_write(5, 40, 0); exp_busy(1, 40);
        compare_all("stab", 60);
        check("stab status", r_st[41], 2'b11);
        check("stab status hold", r_st[59], 2'b11);
        check("stab cycles", r_cyc[41], 40);
        check("stab cycles frozen", r_cyc[59], 40);

        // Reset pulse mid-run, then a clean run
        clear_all(); do_reset();
        st_v[0] = 1; rs_v[25] = 1; st_v[30] = 1;
        run(105);
        exp_issue(1, 24, 0); exp_issue(31, 94, 0);
        exp_write(5, 24, 0); exp_write(35, 98, 0);
        exp_busy(1, 24); exp_busy(31, 98); e_done[99] = 1;
        compare_all("rstmid", 105);
        check("rstmid idx", r_idx[25], 0);
        check("rstmid wa", r_wa[25], 0);
        check("rstmid status", r_st[25], 2'b00);
        check("rstmid cycles", r_cyc[25], 0);
        check("rstmid run cycles", r_cyc[104], 69);
        check("rstmid run status", r_st[104], 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
